// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the hazard/memory sources and the pipeline sequencer.
// Counter outputs exist only when PIPE_PERF_CNT_EN is defined.
interface pipeline_sequencer_if #(
    parameter int CNT_W = 32
);
    logic ihit;
    logic dhit;
    logic exmem_dmem_req;
    logic lw_nop;
    logic jmp_flush;
    logic brch_flush;
    logic memwb_halt;
    logic dflush_done;
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic dmem_allow;
    logic dflush_req;
    logic halt;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    modport slave (
        input  ihit, dhit, exmem_dmem_req, lw_nop,
        input  jmp_flush, brch_flush, memwb_halt, dflush_done,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, dmem_allow, dflush_req, halt
`ifdef PIPE_PERF_CNT_EN
        , output stall_cnt, bubble_cnt, flush_cnt
`endif
    );

    modport master (
        output ihit, dhit, exmem_dmem_req, lw_nop,
        output jmp_flush, brch_flush, memwb_halt, dflush_done,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, dmem_allow, dflush_req, halt
`ifdef PIPE_PERF_CNT_EN
        , input stall_cnt, bubble_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer: RUN / DRAIN / HALTED control of PC and pipeline regs.
// Define PIPE_PERF_CNT_EN to add saturating stall/bubble/flush counters.
module pipeline_sequencer #(
    parameter int CNT_W = 32
) (
    input logic CLK,
    input logic nRST,
    pipeline_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic mem_stall, redirect;
    logic w_halt, w_mem, w_fetch, w_redir, w_bubble;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign mem_stall = bus.exmem_dmem_req & ~bus.dhit;
    assign redirect  = bus.jmp_flush | bus.brch_flush;

    // One-hot priority terms so the decoder below stays exclusive
    assign w_halt   = bus.memwb_halt;
    assign w_mem    = ~w_halt & mem_stall;
    assign w_fetch  = ~w_halt & ~mem_stall & ~bus.ihit;
    assign w_redir  = ~w_halt & ~mem_stall & bus.ihit & redirect;
    assign w_bubble = ~w_halt & ~mem_stall & bus.ihit & ~redirect
                    & bus.lw_nop;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.pc_en      = 1'b0;
        bus.ifid_en    = 1'b0;
        bus.idex_en    = 1'b0;
        bus.exmem_en   = 1'b0;
        bus.memwb_en   = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.dmem_allow = 1'b0;
        unique case (state_q)
            RUN: begin
                bus.dmem_allow = ~w_halt;
                unique case (1'b1)
                    w_halt: state_d = DRAIN;
                    w_mem: begin
                    end
                    w_fetch: begin
                        // A resolved redirect must stay in EX until fetch returns
                        if (!redirect) begin
                            bus.idex_en    = 1'b1;
                            bus.exmem_en   = 1'b1;
                            bus.memwb_en   = 1'b1;
                            bus.idex_flush = 1'b1;
                        end
                    end
                    w_redir: begin
                        bus.pc_en      = 1'b1;
                        bus.ifid_en    = 1'b1;
                        bus.idex_en    = 1'b1;
                        bus.exmem_en   = 1'b1;
                        bus.memwb_en   = 1'b1;
                        bus.ifid_flush = 1'b1;
                        bus.idex_flush = 1'b1;
                    end
                    w_bubble: begin
                        bus.idex_en    = 1'b1;
                        bus.exmem_en   = 1'b1;
                        bus.memwb_en   = 1'b1;
                        bus.idex_flush = 1'b1;
                    end
                    default: begin
                        bus.pc_en    = 1'b1;
                        bus.ifid_en  = 1'b1;
                        bus.idex_en  = 1'b1;
                        bus.exmem_en = 1'b1;
                        bus.memwb_en = 1'b1;
                    end
                endcase
            end
            DRAIN: begin
                if (bus.dflush_done) state_d = HALTED;
            end
            HALTED: begin
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.dflush_req = (state_q == DRAIN);
    assign bus.halt       = (state_q == HALTED);

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic run;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic en
    );
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign run = (state_q == RUN);

    always_comb begin
        stall_d  = sat_inc(stall_q, run & (w_mem | w_fetch));
        bubble_d = sat_inc(bubble_q, run & w_bubble);
        flush_d  = sat_inc(flush_q, run & w_redir);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    assign bus.stall_cnt  = stall_q;
    assign bus.bubble_cnt = bubble_q;
    assign bus.flush_cnt  = flush_q;
`endif
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus
// randomized RUN traffic against a rule-level reference model.
module tb_pipeline_sequencer;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic nRST;
    logic ih, dh, rq, lw, jf, bf, mh, dd;
    int checks = 0;
    int errors = 0;
    int mode;
    longint es, eb, ef;

    always #5 CLK = ~CLK;

    pipeline_sequencer_if #(.CNT_W(W)) bus ();

    assign bus.ihit           = ih;
    assign bus.dhit           = dh;
    assign bus.exmem_dmem_req = rq;
    assign bus.lw_nop         = lw;
    assign bus.jmp_flush      = jf;
    assign bus.brch_flush     = bf;
    assign bus.memwb_halt     = mh;
    assign bus.dflush_done    = dd;

    pipeline_sequencer #(.CNT_W(W)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    //  ifid_flush, idex_flush, dmem_allow, dflush_req, halt}
    function automatic logic [9:0] dut_out();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                bus.memwb_en, bus.ifid_flush, bus.idex_flush,
                bus.dmem_allow, bus.dflush_req, bus.halt};
    endfunction

    function automatic logic [9:0] ref_out();
        logic [4:0] en;
        logic [1:0] fl;
        logic da, dr, h;
        en = 5'b00000;
        fl = 2'b00;
        da = 1'b0;
        dr = (mode == 1);
        h  = (mode == 2);
        if (mode == 0) begin
            da = !mh;
            if (mh) begin
            end else if (rq && !dh) begin
            end else if (!ih) begin
                if (!(jf || bf)) begin
                    en = 5'b00111;
                    fl = 2'b01;
                end
            end else if (jf || bf) begin
                en = 5'b11111;
                fl = 2'b11;
            end else if (lw) begin
                en = 5'b00111;
                fl = 2'b01;
            end else begin
                en = 5'b11111;
            end
        end
        return {en, fl, da, dr, h};
    endfunction

    function automatic longint sat(input longint v);
        return (v >= ((longint'(1) << W) - 1)) ? v : v + 1;
    endfunction

    task automatic apply(input logic a_ih, a_dh, a_rq, a_lw,
                         input logic a_jf, a_bf, a_mh, a_dd);
        @(negedge CLK);
        ih = a_ih; dh = a_dh; rq = a_rq; lw = a_lw;
        jf = a_jf; bf = a_bf; mh = a_mh; dd = a_dd;
        #1;
    endtask

    task automatic advance();
        if (mode == 0) begin
            if (mh) mode = 1;
            else if ((rq && !dh) || !ih) es = sat(es);
            else if (jf || bf) ef = sat(ef);
            else if (lw) eb = sat(eb);
        end else if (mode == 1 && dd) begin
            mode = 2;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        ih = 1'b1; dh = 1'b0; rq = 1'b0; lw = 1'b0;
        jf = 1'b0; bf = 1'b0; mh = 1'b0; dd = 1'b0;
        mode = 0; es = 0; eb = 0; ef = 0;
        #2;
        checks++;
        if (dut_out() !== ref_out()) begin
            errors++;
            $display("FAIL reset_outs got %b want %b", dut_out(), ref_out());
        end
        checks++;
        if ({bus.dflush_req, bus.halt} !== 2'b00) begin
            errors++;
            $display("FAIL reset_halt got %b want 00",
                     {bus.dflush_req, bus.halt});
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if ({bus.stall_cnt, bus.bubble_cnt, bus.flush_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_cnt got %0d %0d %0d want 0 0 0",
                     bus.stall_cnt, bus.bubble_cnt, bus.flush_cnt);
        end
`endif
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_run();
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (dut_out() !== 10'b1111100100) begin
                errors++;
                $display("FAIL run got %b want %b", dut_out(), 10'b1111100100);
            end
            advance();
        end
    endtask

    task automatic test_mem_stall();
        longint s0;
        s0 = es;
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 1, 0, 0, 0, 0, 0);
            checks++;
            if (dut_out() !== 10'b0000000100) begin
                errors++;
                $display("FAIL mem_stall got %b want %b",
                         dut_out(), 10'b0000000100);
            end
            advance();
        end
        apply(1, 1, 1, 0, 0, 0, 0, 0);
        checks++;
        if (dut_out() !== 10'b1111100100) begin
            errors++;
            $display("FAIL mem_release got %b want %b",
                     dut_out(), 10'b1111100100);
        end
        advance();
`ifdef PIPE_PERF_CNT_EN
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.stall_cnt !== W'(s0 + 3)) begin
            errors++;
            $display("FAIL stall_cnt got %0d want %0d", bus.stall_cnt, s0 + 3);
        end
        advance();
`else
        s0 = 0;
`endif
    endtask

    task automatic test_lw_nop();
        apply(1, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if ({bus.pc_en, bus.ifid_en, bus.idex_flush, bus.idex_en}
            !== 4'b0011) begin
            errors++;
            $display("FAIL lw_nop got %b want 0011",
                     {bus.pc_en, bus.ifid_en, bus.idex_flush, bus.idex_en});
        end
        advance();
        apply(1, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (dut_out() !== 10'b1111111100) begin
            errors++;
            $display("FAIL flush_over_lw got %b want %b",
                     dut_out(), 10'b1111111100);
        end
        advance();
`ifdef PIPE_PERF_CNT_EN
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.bubble_cnt, bus.flush_cnt} !== {W'(eb), W'(ef)}) begin
            errors++;
            $display("FAIL bubble_flush_cnt got %0d %0d want %0d %0d",
                     bus.bubble_cnt, bus.flush_cnt, eb, ef);
        end
        advance();
`endif
    endtask

    task automatic test_branch_fetch_stall();
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0, 0, 1, 0, 0);
            checks++;
            if (dut_out() !== 10'b0000000100) begin
                errors++;
                $display("FAIL brch_held got %b want %b",
                         dut_out(), 10'b0000000100);
            end
            advance();
        end
        apply(1, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (dut_out() !== 10'b1111111100) begin
            errors++;
            $display("FAIL brch_go got %b want %b", dut_out(), 10'b1111111100);
        end
        advance();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_out() !== 10'b0011101100) begin
            errors++;
            $display("FAIL fetch_stall got %b want %b",
                     dut_out(), 10'b0011101100);
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 4) != 0, ($urandom % 3) != 0, $urandom % 2,
                  ($urandom % 5) == 0, ($urandom % 8) == 0,
                  ($urandom % 6) == 0, 1'b0, $urandom % 2);
            checks++;
            if (dut_out() !== ref_out()) begin
                errors++;
                $display("FAIL rand_outs cyc %0d got %b want %b",
                         i, dut_out(), ref_out());
            end
`ifdef PIPE_PERF_CNT_EN
            checks++;
            if ({bus.stall_cnt, bus.bubble_cnt, bus.flush_cnt}
                !== {W'(es), W'(eb), W'(ef)}) begin
                errors++;
                $display("FAIL rand_cnt cyc %0d got %0d %0d %0d want %0d %0d %0d",
                         i, bus.stall_cnt, bus.bubble_cnt, bus.flush_cnt,
                         es, eb, ef);
            end
`endif
            advance();
        end
    endtask

    task automatic test_halt_drain();
        apply(1, 0, 1, 1, 0, 1, 1, 0);
        checks++;
        if (dut_out() !== 10'b0000000000) begin
            errors++;
            $display("FAIL halt_wins got %b want %b", dut_out(), 10'b0000000000);
        end
        advance();
        for (int i = 0; i < 5; i++) begin
            apply($urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2,
                  $urandom % 2, $urandom % 2, $urandom % 2, 1'b0);
            checks++;
            if (dut_out() !== 10'b0000000010) begin
                errors++;
                $display("FAIL drain cyc %0d got %b want %b",
                         i, dut_out(), 10'b0000000010);
            end
            advance();
        end
        apply(1, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (dut_out() !== 10'b0000000010) begin
            errors++;
            $display("FAIL drain_done got %b want %b",
                     dut_out(), 10'b0000000010);
        end
        advance();
        for (int i = 0; i < 4; i++) begin
            apply($urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2,
                  $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2);
            checks++;
            if (dut_out() !== 10'b0000000001) begin
                errors++;
                $display("FAIL halted cyc %0d got %b want %b",
                         i, dut_out(), 10'b0000000001);
            end
`ifdef PIPE_PERF_CNT_EN
            checks++;
            if ({bus.stall_cnt, bus.bubble_cnt, bus.flush_cnt}
                !== {W'(es), W'(eb), W'(ef)}) begin
                errors++;
                $display("FAIL frozen_cnt got %0d %0d %0d want %0d %0d %0d",
                         bus.stall_cnt, bus.bubble_cnt, bus.flush_cnt,
                         es, eb, ef);
            end
`endif
            advance();
        end
    endtask

    task automatic test_reset_drain();
        @(negedge CLK);
        nRST = 1'b0;
        mode = 0;
        #1;
        checks++;
        if (bus.halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_clear got %b want 0", bus.halt);
        end
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            apply(($urandom % 3) != 0, 0, 0, ($urandom % 3) == 0,
                  0, ($urandom % 4) == 0, 0, 0);
            advance();
        end
        apply(1, 0, 0, 0, 0, 0, 1, 0);
        advance();
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        advance();
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.dflush_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_drain got %b want 1", bus.dflush_req);
        end
        advance();
        #2;
        nRST = 1'b0;
        mode = 0; es = 0; eb = 0; ef = 0;
        #1;
        checks++;
        if (dut_out() !== ref_out()) begin
            errors++;
            $display("FAIL async_reset got %b want %b", dut_out(), ref_out());
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if ({bus.stall_cnt, bus.bubble_cnt, bus.flush_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset_cnt got %0d %0d %0d want 0 0 0",
                     bus.stall_cnt, bus.bubble_cnt, bus.flush_cnt);
        end
`endif
        @(negedge CLK);
        nRST = 1'b1;
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_out() !== 10'b1111100100) begin
            errors++;
            $display("FAIL run_after_reset got %b want %b",
                     dut_out(), 10'b1111100100);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_mem_stall();
        test_lw_nop();
        test_branch_fetch_stall();
        test_random();
        test_halt_drain();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush sequencer for the five-stage pipeline. It takes the hazard indications (load-use bubble, jump flush, branch flush), the instruction/data memory handshakes and the halt retirement, and drives the PC enable, every pipeline-register enable/flush, and the halt drain sequence. A three-state FSM handles normal run, cache drain on halt, and the terminal halted state. Optional performance counters record stall and flush activity.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter (only used with PIPE_PERF_CNT_EN).

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock, all state on rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- exmem_dmem_req  in  1  MEM stage holds a load/store (dren|dwen)
- lw_nop  in  1  load-use hazard, insert one bubble
- jmp_flush  in  1  jump/JR resolved in EX
- brch_flush  in  1  taken branch resolved in EX
- memwb_halt  in  1  HALT instruction in WB
- dflush_done  in  1  dcache writeback complete
- pc_en  out  1  PC register load enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline-register enables
- ifid_flush, idex_flush  out  1 each  synchronous clear; dominates enable
- dmem_allow  out  1  gate for dren/dwen to data memory
- dflush_req  out  1  request dcache writeback
- halt  out  1  processor halted, sticky
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  (PIPE_PERF_CNT_EN only)

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset -> RUN.
- RUN, priority highest first:
  - memwb_halt=1: all enables 0, pc_en 0, flushes 0, dmem_allow 0; next DRAIN.
  - mem stall (exmem_dmem_req & !dhit): all enables 0, pc_en 0, flushes 0, dmem_allow 1.
  - fetch stall (!ihit): pc_en 0, ifid_en 0, idex_flush 1, idex/exmem/memwb_en 1. A pending jmp/brch flush is held off until ihit=1 (EX is stalled via idex_en=0 in that case: idex_en 0, exmem_en 1 with bubble is not used; EX instruction stays).
  - jmp_flush|brch_flush (with ihit): pc_en 1, all enables 1, ifid_flush 1, idex_flush 1.
  - lw_nop: pc_en 0, ifid_en 0, idex_flush 1, others 1.
  - otherwise: pc_en and all enables 1, flushes 0.
- DRAIN: all enables/pc_en 0, dmem_allow 0, dflush_req 1; dflush_done=1 -> HALTED.
- HALTED: as DRAIN but dflush_req 0, halt 1; leaves only by reset.
- Flush with enable: flushed register loads zero (NOP).

## Timing
- All control outputs combinational from inputs and current state (zero latency); halt and dflush_req decode state only (Moore).
- Reset values: state RUN, halt 0, dflush_req 0, counters 0; control outputs reflect RUN with inputs.
- dflush_req held high every cycle in DRAIN until dflush_done seen; HALTED entered the edge after dflush_done.
- Simultaneous memwb_halt with mem stall, flush or lw_nop: halt wins; younger MEM access suppressed via dmem_allow 0.
- Simultaneous flush and lw_nop: flush wins, no bubble counted.
- Reset asserted mid-DRAIN: immediate return to RUN, dflush_req drops asynchronously.

## Configuration
- PIPE_PERF_CNT_EN defined: stall_cnt increments each RUN cycle with mem or fetch stall; bubble_cnt each cycle lw_nop takes effect; flush_cnt each cycle a jmp/brch flush takes effect. Counters saturate at all-ones, freeze in DRAIN/HALTED.
- Not defined: counter ports and logic absent.

## Test plan
- Reset then ihit=1, no hazards -> pc_en=1, all enables 1, flushes 0, halt=0.
- exmem_dmem_req=1, dhit=0 for 3 cycles then dhit=1 -> all enables 0 for 3 cycles, 1 on 4th; stall_cnt=3.
- lw_nop=1 one cycle -> pc_en=0, ifid_en=0, idex_flush=1; bubble_cnt=1.
- brch_flush=1 with ihit=0 two cycles then ihit=1 -> flushes only on third cycle; flush_cnt=1.
- memwb_halt=1 then dflush_done after 5 cycles -> dflush_req high 5 cycles, halt=1 next edge and stays.
- nRST low during DRAIN -> state RUN, dflush_req=0, counters 0 immediately.
